// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared widths and source encoding for the RAM port arbiter.
//   ADDR_W    : RAM address width (64 KiB unified RAM)
//   DATA_W    : RAM data width (byte-wide)
//   TAG_W     : load destination register tag width
//   SRC_FETCH : source id of instruction fetch
//   SRC_DATA  : source id of the data memory pipeline
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 5;

    localparam logic SRC_FETCH = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    // The read issued last cycle; its data arrives on ram_rdata this cycle.
    typedef struct packed {
        logic             valid;
        logic             src;
        logic [TAG_W-1:0] dest_reg;
    } inflight_t;

    // Payload held in the load response register.
    typedef struct packed {
        logic [TAG_W-1:0]  dest_reg;
        logic [DATA_W-1:0] data;
    } ld_resp_t;

endpackage

// File: rtl/mem_resp_slot.sv
// mem_resp_slot
// Single-entry valid/ready holding register for one response stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fill       : write fill_data this cycle (takes precedence over a drain,
//                so a same-cycle drain and refill keeps valid high)
//   fill_data  : payload to capture
//   valid      : entry occupied
//   ready      : consumer takes the entry when valid & ready
//   data       : held payload (reset to 0)
module mem_resp_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single synchronous-RAM port between instruction fetch and the
// data memory pipeline. At most one request is granted per cycle: data
// loads/stores by default, fetch once the data side has won STARVE_MAX
// consecutive grants while fetch was waiting. Read data returns through one
// valid/ready response register per source, two cycles after the grant.
//
// Parameter:
//   STARVE_MAX : consecutive data grants allowed while fetch waits (1..15)
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_addr/if_valid/if_ready       : fetch request
//   if_rdata/if_rvalid/if_rready    : fetch response
//   dm_addr/dm_dest_reg/dm_wdata/
//   dm_store/dm_valid/dm_ready      : data request (load or store)
//   ld_data/ld_dest_reg/
//   ld_valid/ld_ready               : load response
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata             : RAM port (rdata valid the cycle after a read)
//   stall_count                     : present only with MEM_ARB_PERF_EN;
//                                     saturating count of cycles in which a
//                                     valid request was not granted
// Build option: define MEM_ARB_PERF_EN to add the stall_count counter/port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_addr,
    input  logic        if_valid,
    output logic        if_ready,
    output logic [7:0]  if_rdata,
    output logic        if_rvalid,
    input  logic        if_rready,
    input  logic [15:0] dm_addr,
    input  logic [4:0]  dm_dest_reg,
    input  logic [7:0]  dm_wdata,
    input  logic        dm_store,
    input  logic        dm_valid,
    output logic        dm_ready,
    output logic [7:0]  ld_data,
    output logic [4:0]  ld_dest_reg,
    output logic        ld_valid,
    input  logic        ld_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    inflight_t  inflight;
    logic [3:0] starve;

    logic       fetch_elig;
    logic       load_elig;
    logic       store_elig;
    logic       data_elig;
    logic       fetch_grant;
    logic       data_grant;
    logic       read_grant;

    logic       fetch_fill;
    logic       ld_fill;
    ld_resp_t   ld_fill_data;
    ld_resp_t   ld_held;

    function automatic logic [3:0] starve_inc(input logic [3:0] cur);
        if (cur >= STARVE_LIM)
            return STARVE_LIM;
        return cur + 4'd1;
    endfunction

    // A read may issue only when its response slot is guaranteed free by the
    // time the data lands: nothing of the same source in flight, and the slot
    // empty or being drained right now.
    always_comb begin
        fetch_elig = if_valid
                   & ~(inflight.valid & (inflight.src == SRC_FETCH))
                   & (~if_rvalid | if_rready);
        load_elig  = dm_valid & ~dm_store
                   & ~(inflight.valid & (inflight.src == SRC_DATA))
                   & (~ld_valid | ld_ready);
        store_elig = dm_valid & dm_store;
        data_elig  = load_elig | store_elig;
    end

    // Grants are forced off while reset is held so the RAM sees no access.
    always_comb begin
        fetch_grant = rst_n & fetch_elig & (~data_elig | (starve == STARVE_LIM));
        data_grant  = rst_n & data_elig & ~fetch_grant;
        read_grant  = fetch_grant | (data_grant & ~dm_store);
    end

    always_comb begin
        if_ready  = fetch_grant;
        dm_ready  = data_grant;
        ram_en    = fetch_grant | data_grant;
        ram_we    = data_grant & dm_store;
        ram_addr  = fetch_grant ? if_addr : dm_addr;
        ram_wdata = dm_wdata;
    end

    // Starvation counter: counts data wins while fetch is requesting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= 4'd0;
        end else if (fetch_grant || !if_valid) begin
            starve <= 4'd0;
        end else if (data_grant) begin
            starve <= starve_inc(starve);
        end
    end

    // Track the read issued this cycle; its data arrives next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight.valid    <= read_grant;
            inflight.src      <= fetch_grant ? SRC_FETCH : SRC_DATA;
            inflight.dest_reg <= dm_dest_reg;
        end
    end

    // Read return: route ram_rdata to the slot of the in-flight source.
    always_comb begin
        fetch_fill            = inflight.valid & (inflight.src == SRC_FETCH);
        ld_fill               = inflight.valid & (inflight.src == SRC_DATA);
        ld_fill_data.dest_reg = inflight.dest_reg;
        ld_fill_data.data     = ram_rdata;
    end

    mem_resp_slot #(
        .WIDTH (DATA_W)
    ) u_fetch_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fetch_fill),
        .fill_data (ram_rdata),
        .valid     (if_rvalid),
        .ready     (if_rready),
        .data      (if_rdata)
    );

    mem_resp_slot #(
        .WIDTH (TAG_W + DATA_W)
    ) u_ld_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (ld_fill),
        .fill_data (ld_fill_data),
        .valid     (ld_valid),
        .ready     (ld_ready),
        .data      (ld_held)
    );

    always_comb begin
        ld_data     = ld_held.data;
        ld_dest_reg = ld_held.dest_reg;
    end

`ifdef MEM_ARB_PERF_EN
    logic stalled;

    always_comb begin
        stalled = (if_valid & ~if_ready) | (dm_valid & ~dm_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (stalled && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous-RAM port between instruction fetch and the data memory pipeline. Each cycle it grants at most one request: data loads/stores by default, with a starvation guard for fetch. It returns read data with its tag through per-source valid/ready response registers. It sits between the fetch unit and memory pipeline on one side and the unified 64 KiB RAM on the other.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits; legal range 1..15.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_addr  in  16  fetch address.
- if_valid  in  1  fetch request valid.
- if_ready  out  1  fetch request accepted this cycle.
- if_rdata  out  8  fetch response byte.
- if_rvalid  out  1  fetch response valid.
- if_rready  in  1  fetch response consumed.
- dm_addr  in  16  data address from memory pipeline.
- dm_dest_reg  in  5  load destination tag.
- dm_wdata  in  8  store data.
- dm_store  in  1  1 = store, 0 = load.
- dm_valid  in  1  data request valid.
- dm_ready  out  1  data request accepted this cycle.
- ld_data  out  8  load response byte.
- ld_dest_reg  out  5  load response tag.
- ld_valid  out  1  load response valid.
- ld_ready  in  1  load response consumed.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write this cycle.
- ram_addr  out  16  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after a read.
- stall_count  out  16  only with MEM_ARB_PERF_EN; saturating count of cycles with a valid request not granted.

## Operation
- State:
  - inflight (valid, src, dest_reg): the read issued last cycle.
  - One response register per source.
  - starve counter, 4 bits.
- Eligibility:
  - Fetch read is eligible when if_valid, no fetch read is in flight, and the fetch response register is empty or drained this cycle (if_rvalid & if_rready).
  - Data load is eligible under the same rule against the load response register.
  - Store is eligible whenever dm_valid; stores need no response slot.
- Priority:
  - An eligible data request wins unless starve == STARVE_MAX and fetch is eligible; in that case fetch wins.
  - Only the winner sees ready=1; the other ready=0. At most one grant per cycle.
- starve counter:
  - Increments (saturating at STARVE_MAX) on a data grant while if_valid is high.
  - Clears on a fetch grant, or when if_valid is low.
- Memory drive, combinational from the grant:
  - ram_en = any grant; ram_we = data grant & dm_store.
  - ram_addr and ram_wdata are taken from the winner.
  - With no grant, ram_en = ram_we = 0; ram_addr and ram_wdata are don't-care.
- Read return:
  - The cycle after a read grant, ram_rdata is written into the inflight source's response register, with dest_reg for data loads; inflight clears.
  - A response register holds its contents until consumed by valid & ready.
- Stores complete at grant and produce no response. A store never delays a pending load response.
- Order: responses per source return in request order. There is no cross-source ordering.

## Timing
- Request granted in cycle N. The RAM registers the address/write at the end of N.
- ram_rdata is sampled at the end of N+1. if_rvalid/ld_valid go high in N+2. Load-to-response latency is 2 cycles.
- Store is written into the RAM at the end of the grant cycle; a load granted in N+1 to the same address returns the new data.
- Maximum read throughput is one read per 2 cycles per source. Alternating sources sustain one access per cycle.
- Reset values, asserted asynchronously:
  - if_rvalid = ld_valid = 0; inflight valid = 0; starve = 0; stall_count = 0.
  - if_ready = dm_ready = 0 and ram_en = ram_we = 0 while rst_n is low.
  - Response data/tag registers = 0.
- Reset mid-read: the in-flight read is discarded and no response is produced after deassertion.
- Simultaneous drain and refill of a response register in one cycle is legal; the new data replaces the old with valid held high.

## Configuration
- MEM_ARB_PERF_EN:
  - Defined: stall_count exists. It increments by 1 on any cycle where (if_valid & !if_ready) | (dm_valid & !dm_ready), saturating at 16'hFFFF.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - localparams ADDR_W=16, DATA_W=8, TAG_W=5.
  - Source encoding SRC_FETCH=0, SRC_DATA=1.
- One sub-module, mem_resp_slot: a single-entry valid/ready holding register parameterised on payload width, instantiated once per source.

## Test plan
- Reset, then dm load at 16'h0200 (RAM holds 8'h5A), dest_reg 5'd7, ld_ready=1 → dm_ready=1 in cycle 0; ld_valid=1 in cycle 2 with ld_data=8'h5A, ld_dest_reg=7; ld_valid low in cycle 3.
- Store 8'hC3 to 16'h0300 in cycle 0, load 16'h0300 in cycle 1 → ram_we=1 only in cycle 0; load returns 8'hC3 in cycle 3.
- if_valid and dm_valid held high continuously with STARVE_MAX=4, all stores → data granted 4 cycles, then fetch granted 1 cycle; pattern repeats; starve counter clears on each fetch grant.
- Fetch response held with if_rready=0 and if_valid held → no further fetch grant; if_rdata stable. Raising if_rready for one cycle → new fetch grant that same cycle.
- rst_n pulled low in cycle 1 of an outstanding load → ld_valid stays 0 after release; ram_en=0 during reset.
- With MEM_ARB_PERF_EN: dm_valid held, ld_ready=0 for 10 cycles after one load fills the slot → stall_count increases by exactly the number of ungranted cycles.
